dmem_ctrl: RTL and testbench

Parametrised data-memory controller replacing the single-cycle word-only data RAM on the CPU's load/store path. Adds byte/halfword/word stores with byte-lane enables, sign- or zero-extended sub-word loads, alignment checking and a configurable wait-state count with a req/ready handshake, so the pipeline can stall on slower memories. Storage is little-endian and word-addressed internally; byte addresses arrive from the ALU.

---
 rtl/dmem_pkg.sv | 59 +++++
 rtl/dmem_array.sv | 41 ++++
 rtl/dmem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access size codes,
// FSM states and the alignment / lane-mask / load-extension helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // True when the byte address is naturally aligned for the access size.
  // A dword access is only legal on a 64-bit memory.
  function automatic logic dmem_aligned(input logic [1:0] sz, input logic [2:0] a,
                                        input logic dw64);
    logic ok;
    case (sz)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (a[0] == 1'b0);
      SZ_W:    ok = (a[1:0] == 2'b00);
      SZ_D:    ok = dw64 && (a[2:0] == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte-lane enables for an access of the given size at lane offset off.
  function automatic logic [7:0] dmem_lane_mask(input logic [1:0] sz, input logic [2:0] off);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      SZ_D:    m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m << off;
  endfunction

  // Pull the addressed bytes down to bit 0 and sign/zero extend them.
  function automatic logic [63:0] dmem_load_ext(input logic [63:0] w, input logic [2:0] off,
                                                input logic [1:0] sz, input logic u);
    logic [63:0] s;
    logic [63:0] r;
    s = w >> {off, 3'b000};
    case (sz)
      SZ_B:    r = u ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
      SZ_H:    r = u ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      SZ_W:    r = u ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      SZ_D:    r = s;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word-organised RAM with per-byte write enables and a
// registered read port. The storage itself is never reset.
module dmem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic                    i_re,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-lane writes into the storage array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (i_be[i]) begin
        r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
  end

  // Read register; only updated by loads so the last load result is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: sub-word stores with lane enables, extended
// sub-word loads, alignment trap and a fixed wait-state handshake.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BUS_WIDTH   = 17,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [BUS_WIDTH-1:0]  adr,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  ready,
  output logic                  misaligned,
  output logic                  busy
);

  localparam int         LANES    = DATA_WIDTH / 8;
  localparam int         OFF_W    = $clog2(LANES);
  localparam int         WADR_W   = BUS_WIDTH - OFF_W;
  localparam logic [2:0] CNT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic       IS64     = (DATA_WIDTH == 64);

  state_e                r_state, w_state_nxt;
  logic [2:0]            r_cnt, w_cnt_nxt;
  logic [BUS_WIDTH-1:0]  r_adr;
  logic                  r_we, r_uns;
  logic [1:0]            r_size;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_ready, r_mis;
  logic [2:0]            r_ld_off;
  logic [1:0]            r_ld_size;
  logic                  r_ld_uns;

  logic                  w_start, w_aligned, w_go, w_bad, w_fire, w_in_wait;
  logic [BUS_WIDTH-1:0]  w_acc_adr;
  logic                  w_acc_we, w_acc_uns;
  logic [1:0]            w_acc_size;
  logic [DATA_WIDTH-1:0] w_acc_wdata, w_wd, w_rdata;
  logic [2:0]            w_off;
  logic [LANES-1:0]      w_mask, w_be;
  logic                  w_re;

  assign w_start   = (r_state == ST_IDLE) && req;
  assign w_aligned = dmem_aligned(size, adr[2:0], IS64);
  assign w_go      = w_start && w_aligned;
  assign w_bad     = w_start && !w_aligned;
  assign w_in_wait = (r_state == ST_WAIT);

  // Zero wait states: access on the sampling edge; otherwise when the countdown expires.
  assign w_fire = (WAIT_STATES == 0) ? w_go : (w_in_wait && (r_cnt == 3'd0));

  // During WAIT the latched request drives the array; the live bus is ignored.
  assign w_acc_adr   = w_in_wait ? r_adr   : adr;
  assign w_acc_we    = w_in_wait ? r_we    : we;
  assign w_acc_size  = w_in_wait ? r_size  : size;
  assign w_acc_uns   = w_in_wait ? r_uns   : uns;
  assign w_acc_wdata = w_in_wait ? r_wdata : writedata;

  assign w_off  = 3'(w_acc_adr[OFF_W-1:0]);
  assign w_mask = LANES'(dmem_lane_mask(w_acc_size, w_off));
  assign w_wd   = DATA_WIDTH'(64'(w_acc_wdata) << {w_off, 3'b000});
  assign w_be   = (w_fire && w_acc_we) ? w_mask : '0;
  assign w_re   = w_fire && !w_acc_we;

  dmem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(WADR_W)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_be   (w_be),
    .i_re   (w_re),
    .i_addr (w_acc_adr[BUS_WIDTH-1:OFF_W]),
    .i_wdata(w_wd),
    .o_rdata(w_rdata)
  );

  // Next-state and wait counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_go && (WAIT_STATES != 0)) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CNT_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the accepted request so it stays stable across the wait states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr   <= '0;
      r_we    <= 1'b0;
      r_size  <= SZ_B;
      r_uns   <= 1'b0;
      r_wdata <= '0;
    end else if (w_go) begin
      r_adr   <= adr;
      r_we    <= we;
      r_size  <= size;
      r_uns   <= uns;
      r_wdata <= writedata;
    end
  end

  // Completion pulse and misalignment flag, one cycle after the deciding edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_ready <= w_fire || w_bad;
      r_mis   <= w_bad;
    end
  end

  // Remember how the last load wants its data shaped; pairs with the RAM read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_off  <= 3'd0;
      r_ld_size <= SZ_B;
      r_ld_uns  <= 1'b0;
    end else if (w_re) begin
      r_ld_off  <= w_off;
      r_ld_size <= w_acc_size;
      r_ld_uns  <= w_acc_uns;
    end
  end

  assign readdata   = DATA_WIDTH'(dmem_load_ext(64'(w_rdata), r_ld_off, r_ld_size, r_ld_uns));
  assign ready      = r_ready;
  assign misaligned = r_mis;
  assign busy       = (r_state == ST_WAIT);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a 32-bit zero-wait instance and a 64-bit three-wait
// instance share one stimulus bus and are checked against a byte-array model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int BW  = 12;
  localparam int WS1 = 3;

  logic        clk = 1'b0;
  logic        rst_n, req0, req1, we, uns;
  logic [1:0]  size;
  logic [BW-1:0] adr;
  logic [63:0] wd;
  logic [31:0] rd0;
  logic [63:0] rd1;
  logic        rdy0, mis0, busy0, rdy1, mis1, busy1;

  always #5 clk = ~clk;

  dmem_ctrl #(.DATA_WIDTH(32), .BUS_WIDTH(BW), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .size(size), .uns(uns),
    .adr(adr), .writedata(wd[31:0]), .readdata(rd0), .ready(rdy0),
    .misaligned(mis0), .busy(busy0));

  dmem_ctrl #(.DATA_WIDTH(64), .BUS_WIDTH(BW), .WAIT_STATES(WS1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .we(we), .size(size), .uns(uns),
    .adr(adr), .writedata(wd), .readdata(rd1), .ready(rdy1),
    .misaligned(mis1), .busy(busy1));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mdl [2][4096];
  logic [63:0] last_rd [2];

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    int          a;
    logic [63:0] d;
    logic        m0;
    logic [31:0] r0;
    logic        m1;
    logic [63:0] r1;
  } vec_t;

  vec_t tab [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: memory as a byte array; k=0 is the 32-bit instance, k=1 the 64-bit one.
  task automatic model_step(input int k, input logic w, input logic [1:0] sz, input logic u,
                            input int a, input logic [63:0] d,
                            output logic em, output logic [63:0] er);
    int n = 1 << sz;
    logic [63:0] v;
    em = ((sz == 2'd3) && (k == 0)) || ((a % n) != 0);
    if (!em) begin
      if (w) begin
        for (int i = 0; i < n; i++) mdl[k][a+i] = d[8*i +: 8];
      end else begin
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(mdl[k][a+i]) << (8*i));
        if (!u && (n < 8) && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        if (k == 0) v = v & 64'h0000_0000_FFFF_FFFF;
        last_rd[k] = v;
      end
    end
    er = last_rd[k];
  endtask

  // One request to both instances; checks latency, single pulse, flags, data and busy.
  task automatic do_access(input string tag, input logic w, input logic [1:0] sz, input logic u,
                           input int a, input logic [63:0] d, input bit tab_exp,
                           input logic tm0, input logic [63:0] tr0,
                           input logic tm1, input logic [63:0] tr1);
    logic em0, em1, cm0, cm1, busy_ok;
    logic [63:0] er0, er1, cr0, cr1;
    int lat1, got0, got1, n0, n1;
    model_step(0, w, sz, u, a, d, em0, er0);
    model_step(1, w, sz, u, a, d, em1, er1);
    if (tab_exp) begin
      em0 = tm0; er0 = tr0; em1 = tm1; er1 = tr1;
    end
    lat1 = em1 ? 1 : 1 + WS1;
    @(negedge clk);
    we = w; size = sz; uns = u; adr = a[BW-1:0]; wd = d; req0 = 1'b1; req1 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    got0 = -1; got1 = -1; n0 = 0; n1 = 0; busy_ok = 1'b1;
    cm0 = 1'bx; cm1 = 1'bx; cr0 = 'x; cr1 = 'x;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (rdy0) begin
        n0++;
        if (got0 < 0) begin got0 = c; cm0 = mis0; cr0 = {32'd0, rd0}; end
      end
      if (rdy1) begin
        n1++;
        if (got1 < 0) begin got1 = c; cm1 = mis1; cr1 = rd1; end
      end
      if (busy1 !== (c < lat1)) busy_ok = 1'b0;
      if (busy0 !== 1'b0) busy_ok = 1'b0;
    end
    check({tag, "_lat0"}, 64'(got0), 64'd1);
    check({tag, "_pulses0"}, 64'(n0), 64'd1);
    check({tag, "_mis0"}, 64'(cm0), 64'(em0));
    check({tag, "_rd0"}, cr0, er0);
    check({tag, "_lat1"}, 64'(got1), 64'(lat1));
    check({tag, "_pulses1"}, 64'(n1), 64'd1);
    check({tag, "_mis1"}, 64'(cm1), 64'(em1));
    check({tag, "_rd1"}, cr1, er1);
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
  endtask

  // Back-to-back zero-wait accesses on the 32-bit instance, one per cycle.
  task automatic b2b_seq();
    logic [1:0]  osz [5] = '{SZ_W, SZ_W, SZ_B, SZ_B, SZ_W};
    logic        ow  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] od  [5] = '{64'hDEADBEEF, 64'd0, 64'h80, 64'd0, 64'd0};
    int          oa  [5] = '{'h200, 'h200, 'h203, 'h203, 'h200};
    logic        pm;
    logic [63:0] pr;
    pm = 1'b0; pr = 64'd0;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c > 0) begin
        check($sformatf("b2b%0d_rdy", c), 64'(rdy0), 64'd1);
        check($sformatf("b2b%0d_mis", c), 64'(mis0), 64'(pm));
        check($sformatf("b2b%0d_rd", c), {32'd0, rd0}, pr);
      end
      if (c < 5) begin
        we = ow[c]; size = osz[c]; uns = 1'b0; adr = oa[c][BW-1:0]; wd = od[c];
        req0 = 1'b1; req1 = 1'b0;
        model_step(0, ow[c], osz[c], 1'b0, oa[c], od[c], pm, pr);
      end else begin
        req0 = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_idle", 64'(rdy0), 64'd0);
  endtask

  // Wait-state instance: requests and bus changes while busy must be ignored.
  task automatic ws_ignore_seq();
    logic em;
    logic [63:0] er;
    int got;
    logic bok;
    model_step(1, 1'b0, SZ_W, 1'b0, 'h10, 64'd0, em, er);
    @(negedge clk);
    we = 1'b0; size = SZ_W; uns = 1'b0; adr = 'h10; req1 = 1'b1; req0 = 1'b0;
    @(posedge clk);
    #1;
    we = 1'b1; wd = 64'hBAD0BAD0_BAD0BAD0; adr = 'h10;
    got = -1; bok = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 4) req1 = 1'b0;
      if (rdy1 && (got < 0)) got = c;
      if (busy1 !== (c < 4)) bok = 1'b0;
    end
    check("ws_lat", 64'(got), 64'd4);
    check("ws_busy", 64'(bok), 64'd1);
    check("ws_mis", 64'(mis1), 64'd0);
    check("ws_rd", rd1, er);
    do_access("ws_after", 1'b0, SZ_W, 1'b0, 'h10, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
  endtask

  // Reset in the middle of a pending store: nothing commits, no ready pulse.
  task automatic reset_wait_seq();
    logic seen;
    do_access("pre20", 1'b1, SZ_W, 1'b0, 'h20, 64'h11112222, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    @(negedge clk);
    we = 1'b1; size = SZ_W; adr = 'h20; wd = 64'hCAFEF00D; req1 = 1'b1; req0 = 1'b0;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    @(negedge clk);
    check("rst_pending_busy", 64'(busy1), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_rd0", {32'd0, rd0}, 64'd0);
    check("rst_rd1", rd1, 64'd0);
    check("rst_flags", 64'({rdy0, mis0, busy0, rdy1, mis1, busy1}), 64'd0);
    last_rd[0] = 64'd0; last_rd[1] = 64'd0;
    repeat (3) @(negedge clk);
    check("rst_held_flags", 64'({rdy0, mis0, busy0, rdy1, mis1, busy1}), 64'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rdy0 || rdy1) seen = 1'b1;
    end
    check("rst_no_ready", 64'(seen), 64'd0);
    do_access("post20", 1'b0, SZ_W, 1'b0, 'h20, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
  endtask

  initial begin
    tab[0]  = '{1'b1, SZ_W, 1'b0, 32'h08, 64'hA5A5A5A5,            1'b0, 32'h0,        1'b0, 64'h0};
    tab[1]  = '{1'b1, SZ_W, 1'b0, 32'h0C, 64'h55555555,            1'b0, 32'h0,        1'b0, 64'h0};
    tab[2]  = '{1'b1, SZ_W, 1'b0, 32'h10, 64'h99999999_DEADBEEF,   1'b0, 32'h0,        1'b0, 64'h0};
    tab[3]  = '{1'b0, SZ_W, 1'b0, 32'h10, 64'h0,                   1'b0, 32'hDEADBEEF, 1'b0, 64'hFFFFFFFF_DEADBEEF};
    tab[4]  = '{1'b1, SZ_B, 1'b0, 32'h13, 64'hAAAAAAAA_AAAAAA80,   1'b0, 32'hDEADBEEF, 1'b0, 64'hFFFFFFFF_DEADBEEF};
    tab[5]  = '{1'b0, SZ_B, 1'b0, 32'h13, 64'h0,                   1'b0, 32'hFFFFFF80, 1'b0, 64'hFFFFFFFF_FFFFFF80};
    tab[6]  = '{1'b0, SZ_B, 1'b1, 32'h13, 64'h0,                   1'b0, 32'h00000080, 1'b0, 64'h00000000_00000080};
    tab[7]  = '{1'b0, SZ_W, 1'b0, 32'h10, 64'h0,                   1'b0, 32'h80ADBEEF, 1'b0, 64'hFFFFFFFF_80ADBEEF};
    tab[8]  = '{1'b1, SZ_H, 1'b0, 32'h12, 64'hFFFFFFFF_FFFF1234,   1'b0, 32'h80ADBEEF, 1'b0, 64'hFFFFFFFF_80ADBEEF};
    tab[9]  = '{1'b0, SZ_H, 1'b1, 32'h12, 64'h0,                   1'b0, 32'h00001234, 1'b0, 64'h00000000_00001234};
    tab[10] = '{1'b0, SZ_H, 1'b0, 32'h11, 64'h0,                   1'b1, 32'h00001234, 1'b1, 64'h00000000_00001234};
    tab[11] = '{1'b0, SZ_W, 1'b0, 32'h10, 64'h0,                   1'b0, 32'h1234BEEF, 1'b0, 64'h00000000_1234BEEF};
    tab[12] = '{1'b1, SZ_D, 1'b0, 32'h08, 64'h01234567_89ABCDEF,   1'b1, 32'h1234BEEF, 1'b0, 64'h00000000_1234BEEF};
    tab[13] = '{1'b0, SZ_W, 1'b0, 32'h0C, 64'h0,                   1'b0, 32'h55555555, 1'b0, 64'h00000000_01234567};
    tab[14] = '{1'b1, SZ_D, 1'b0, 32'h04, 64'hFFFFFFFF_FFFFFFFF,   1'b1, 32'h55555555, 1'b1, 64'h00000000_01234567};
    tab[15] = '{1'b0, SZ_D, 1'b0, 32'h08, 64'h0,                   1'b1, 32'h55555555, 1'b0, 64'h01234567_89ABCDEF};
    tab[16] = '{1'b0, SZ_W, 1'b0, 32'h08, 64'h0,                   1'b0, 32'hA5A5A5A5, 1'b0, 64'hFFFFFFFF_89ABCDEF};
    tab[17] = '{1'b0, SZ_W, 1'b1, 32'h08, 64'h0,                   1'b0, 32'hA5A5A5A5, 1'b0, 64'h00000000_89ABCDEF};
    tab[18] = '{1'b0, SZ_H, 1'b0, 32'h0A, 64'h0,                   1'b0, 32'hFFFFA5A5, 1'b0, 64'hFFFFFFFF_FFFF89AB};

    last_rd[0] = 64'd0; last_rd[1] = 64'd0;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we = 1'b0; size = SZ_B; uns = 1'b0;
    adr = '0; wd = 64'd0;
    #12;
    check("reset_rd0", {32'd0, rd0}, 64'd0);
    check("reset_rd1", rd1, 64'd0);
    check("reset_flags", 64'({rdy0, mis0, busy0, rdy1, mis1, busy1}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      do_access($sformatf("tab%0d", i), tab[i].w, tab[i].sz, tab[i].u, tab[i].a, tab[i].d,
                1'b1, tab[i].m0, {32'd0, tab[i].r0}, tab[i].m1, tab[i].r1);
    end

    b2b_seq();
    ws_ignore_seq();
    reset_wait_seq();

    for (int a = 'h100; a < 'h140; a += 4) begin
      do_access("init", 1'b1, SZ_W, 1'b0, a, 64'($urandom), 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    end
    for (int i = 0; i < 250; i++) begin
      do_access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 'h100 + int'($urandom_range(0, 63)),
                {32'($urandom), 32'($urandom)}, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
